de2_115_sopc_avalon_st_ready_latency_expander: RTL and testbench

DE2_115_SOPC_AVALON_ST_READY_LATENCY_EXPANDER -- requirements
Module: de2_115_sopc_avalon_st_ready_latency_expander

---
 rtl/de2_115_sopc_avalon_st_ready_latency_expander_pkg.sv | 23 ++
 rtl/de2_115_sopc_avalon_st_ready_latency_expander_fifo.sv | 74 +++++++
 rtl/de2_115_sopc_avalon_st_ready_latency_expander.sv | 89 ++++++++
 tb/tb_de2_115_sopc_avalon_st_ready_latency_expander.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/de2_115_sopc_avalon_st_ready_latency_expander_pkg.sv
// rtl/de2_115_sopc_avalon_st_ready_latency_expander_pkg.sv - shared widths, defaults and payload layout
package de2_115_sopc_avalon_st_ready_latency_expander_pkg;

  localparam int DATA_W    = 32;
  localparam int ERROR_W   = 6;
  localparam int SOP_W     = 1;
  localparam int EOP_W     = 1;
  localparam int EMPTY_W   = 2;
  localparam int PAYLOAD_W = DATA_W + ERROR_W + SOP_W + EOP_W + EMPTY_W;

  localparam int DEFAULT_READY_LATENCY = 2;
  localparam int DEFAULT_DEPTH         = 4;

  // Beat payload as stored in the buffer; data occupies the MSBs.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ERROR_W-1:0] error;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } payload_t;

endpackage

// File: rtl/de2_115_sopc_avalon_st_ready_latency_expander_fifo.sv
// rtl/de2_115_sopc_avalon_st_ready_latency_expander_fifo.sv - synchronous payload FIFO with combinational head
module de2_115_sopc_avalon_st_ready_latency_expander_fifo
  import de2_115_sopc_avalon_st_ready_latency_expander_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = PAYLOAD_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PTR_W:0]   fill_level_o
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic             do_push;
  logic             do_pop;
  logic             not_empty;

  assign not_empty = (fill_q != '0);

  // Guard push at full and pop at empty so the count never wraps.
  always_comb begin
    do_push  = push_i && (fill_q != FULL_LVL);
    do_pop   = pop_i && not_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      fill_d = fill_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) fill_d = fill_q - (PTR_W+1)'(1);
  end

  // Pointer and fill registers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Payload storage; entries are only observed while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Remember the last head shown so the output holds steady once the buffer drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (not_empty) begin
      hold_q <= mem_q[rd_ptr_q];
    end
  end

  assign head_o       = not_empty ? mem_q[rd_ptr_q] : hold_q;
  assign fill_level_o = fill_q;

endmodule

// File: rtl/de2_115_sopc_avalon_st_ready_latency_expander.sv
// rtl/de2_115_sopc_avalon_st_ready_latency_expander.sv - ready-latency-0 sink to ready-latency-N source adapter
module de2_115_sopc_avalon_st_ready_latency_expander
  import de2_115_sopc_avalon_st_ready_latency_expander_pkg::*;
#(
  parameter int READY_LATENCY = DEFAULT_READY_LATENCY,
  parameter int DEPTH         = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [ERROR_W-1:0] in_error,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [ERROR_W-1:0] out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [READY_LATENCY-1:0] grant_hist_q, grant_hist_d;
  logic                     grant;
  logic [PTR_W:0]           fill_level;
  logic                     push;
  logic                     pop;
  payload_t                 in_beat;
  payload_t                 out_beat;

  // Grant history: out_ready enters at bit 0 and the oldest sample is the current grant.
  generate
    if (READY_LATENCY == 1) begin : g_hist_one
      always_comb grant_hist_d = out_ready;
    end else begin : g_hist_many
      always_comb grant_hist_d = {grant_hist_q[READY_LATENCY-2:0], out_ready};
    end
  endgenerate

  // Grant history register, cleared so no stale grant survives reset.
  always_ff @(posedge clk) begin
    if (reset) grant_hist_q <= '0;
    else       grant_hist_q <= grant_hist_d;
  end

  assign grant = grant_hist_q[READY_LATENCY-1];

  // Ready/valid equations; a grant with nothing buffered is simply lost.
  assign in_ready  = !reset && (fill_level < FULL_LVL);
  assign out_valid = grant && (fill_level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid;

  // Pack the sink fields into one buffer word.
  always_comb begin
    in_beat       = '0;
    in_beat.data  = in_data;
    in_beat.error = in_error;
    in_beat.sop   = in_startofpacket;
    in_beat.eop   = in_endofpacket;
    in_beat.empty = in_empty;
  end

  de2_115_sopc_avalon_st_ready_latency_expander_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_data_i  (in_beat),
    .pop_i        (pop),
    .head_o       (out_beat),
    .fill_level_o (fill_level)
  );

  assign out_data          = out_beat.data;
  assign out_error         = out_beat.error;
  assign out_startofpacket = out_beat.sop;
  assign out_endofpacket   = out_beat.eop;
  assign out_empty         = out_beat.empty;

endmodule

// File: tb/tb_de2_115_sopc_avalon_st_ready_latency_expander.sv
// tb/tb_de2_115_sopc_avalon_st_ready_latency_expander.sv - self-checking bench for the ready latency expander
module tb_de2_115_sopc_avalon_st_ready_latency_expander;

  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready, in_valid, in_sop, in_eop;
  logic [31:0] in_data;
  logic [5:0]  in_error;
  logic [1:0]  in_empty;
  logic        out_ready, out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic [5:0]  out_error;
  logic [1:0]  out_empty;
  logic [41:0] out_beat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  de2_115_sopc_avalon_st_ready_latency_expander #(
    .READY_LATENCY (RL),
    .DEPTH         (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_error),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_error),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty)
  );

  assign out_beat = {out_data, out_error, out_sop, out_eop, out_empty};

  // Reference model: queue of buffered beats, delay line of out_ready samples, last shown head.
  logic [41:0] mq[$];
  logic        gq[$];
  logic [41:0] m_last;
  logic        m_grant;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      gq.delete();
      for (int i = 0; i < RL; i++) gq.push_back(1'b0);
      m_last = '0;
    end else begin
      m_grant = gq.pop_front();
      if (mq.size() != 0) begin
        m_last = mq[0];
        if (m_grant) void'(mq.pop_front());
      end
      if (in_valid && (mq.size() + (m_grant && mq.size() != 0 ? 0 : 0)) < DEPTH + 0 && in_ready_model_ok())
        mq.push_back({in_data, in_error, in_sop, in_eop, in_empty});
      gq.push_back(out_ready);
    end
  end

  // Acceptance is decided on the fill seen before this edge's pop, tracked separately.
  int m_fill_before;
  always @(negedge clk) m_fill_before = mq.size();
  function automatic bit in_ready_model_ok();
    return m_fill_before < DEPTH;
  endfunction

  function automatic logic exp_in_ready();
    return !reset && (mq.size() < DEPTH);
  endfunction
  function automatic logic exp_out_valid();
    return (gq.size() == RL) && gq[0] && (mq.size() != 0);
  endfunction
  function automatic logic [41:0] exp_payload();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  function automatic logic [41:0] kbeat(input int k);
    return {32'(k), 6'(k), 1'b0, 1'b0, 2'(k)};
  endfunction
  function automatic logic [41:0] rbeat();
    return {$urandom, 10'($urandom)};
  endfunction

  // Drive one cycle of inputs after the falling edge, then settle before sampling.
  task automatic step(input logic v, input logic [41:0] b, input logic r, input logic rst);
    @(negedge clk);
    in_valid  = v;
    {in_data, in_error, in_sop, in_eop, in_empty} = b;
    out_ready = r;
    reset     = rst;
    #1;
  endtask

  task automatic test_reset();
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    step(0, '0, 1, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_beat !== 42'd0) begin bad++; $display("FAIL post_reset_payload got=%h want=0", out_beat); end
    step(0, '0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid2 got=%b want=0", out_valid); end
  endtask

  task automatic test_single_beat();
    logic [41:0] b;
    b = {32'hA5A5_0001, 6'h00, 1'b1, 1'b1, 2'd2};
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    step(1, b, 1, 0);
    step(0, '0, 1, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_beat !== b) begin bad++; $display("FAIL single_payload got=%h want=%h", out_beat, b); end
    step(0, '0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_grant_timing();
    int n, at;
    n = 0; at = -1;
    for (int i = 0; i < RL + 1; i++) step(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rbeat(), 0, 0);
    for (int c = 0; c < 16; c++) begin
      step(0, '0, (c == 10), 0);
      if (out_valid === 1'b1) begin n++; at = c; end
    end
    total++; if (n != 1) begin bad++; $display("FAIL grant_count got=%0d want=1", n); end
    total++; if (at != 12) begin bad++; $display("FAIL grant_cycle got=%0d want=12", at); end
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
  endtask

  task automatic test_fill_full();
    int got[$];
    bit first_seen, check_next;
    first_seen = 0; check_next = 0;
    for (int i = 0; i < RL + 1; i++) step(0, '0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, kbeat(k), 0, 0);
    step(1, kbeat(5), 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    step(1, kbeat(5), 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_blocks_5th got=%b want=0", in_ready); end
    for (int c = 0; c < RL + 8; c++) begin
      step(0, '0, 1, 0);
      if (check_next) begin
        check_next = 0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (!first_seen) begin
          first_seen = 1; check_next = 1;
          total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_in_pop got=%b want=0", in_ready); end
        end
        got.push_back(int'(out_data));
      end
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL full_drain_count got=%0d want=4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      total++; if (got[k] != k + 1) begin bad++; $display("FAIL full_drain_order idx=%0d got=%0d want=%0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_concurrent_full();
    int got[$];
    int idx;
    logic v;
    idx = 5;
    for (int i = 0; i < RL + 1; i++) step(0, '0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, kbeat(k), 0, 0);
    for (int c = 0; c < 80 && got.size() < 12; c++) begin
      v = (idx <= 12);
      step(v, kbeat(idx), 1, 0);
      if (v && in_ready === 1'b1) idx++;
      if (out_valid === 1'b1) got.push_back(int'(out_data));
    end
    total++; if (got.size() != 12) begin bad++; $display("FAIL stream_count got=%0d want=12", got.size()); end
    for (int k = 0; k < got.size() && k < 12; k++) begin
      total++; if (got[k] != k + 1) begin bad++; $display("FAIL stream_order idx=%0d got=%0d want=%0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_empty_grant();
    int hi;
    logic [41:0] b;
    hi = 0;
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, '0, 1, 0);
      if (out_valid !== 1'b0) hi++;
    end
    total++; if (hi != 0) begin bad++; $display("FAIL empty_grant_valid got=%0d want=0", hi); end
    b = rbeat();
    step(1, b, 1, 0);
    step(0, '0, 1, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL empty_then_push_valid got=%b want=1", out_valid); end
    total++; if (out_beat !== b) begin bad++; $display("FAIL empty_then_push_payload got=%h want=%h", out_beat, b); end
  endtask

  task automatic test_reset_midstream();
    int hi;
    hi = 0;
    for (int i = 0; i < RL + 2; i++) step(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rbeat(), 0, 0);
    step(0, '0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      step(0, '0, 1, 0);
      if (out_valid !== 1'b0) hi++;
    end
    total++; if (hi != 0) begin bad++; $display("FAIL midreset_stale got=%0d want=0", hi); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_random();
    logic rst, v, r;
    int vw, rw;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) begin vw = $urandom_range(1, 9); rw = $urandom_range(1, 9); end
      rst = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 9) < vw);
      r   = ($urandom_range(0, 9) < rw);
      step(v, rbeat(), r, rst);
      total++; if (in_ready !== exp_in_ready()) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", c, in_ready, exp_in_ready()); end
      if (!rst) begin
        total++; if (out_valid !== exp_out_valid()) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", c, out_valid, exp_out_valid()); end
        total++; if (out_beat !== exp_payload()) begin bad++; $display("FAIL rnd_payload cyc=%0d got=%h want=%h", c, out_beat, exp_payload()); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_error = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    test_reset();
    test_single_beat();
    test_grant_timing();
    test_fill_full();
    test_concurrent_full();
    test_empty_grant();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
